// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM states, parameter defaults
// and the data width.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 347;
  localparam int unsigned FIFO_DEPTH_DEFAULT   = 4;
  localparam int unsigned DATA_W               = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO: synchronous write and read, combinational head output,
// full/empty/count status. A write while full is accepted only alongside a read.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [PTR_W:0]    count_o
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_wr, do_rd;

  assign full_o    = (count_q == DEPTH_C);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_rd    = rd_en_i & ~empty_o;
  assign do_wr    = wr_en_i & (~full_o | do_rd);
  assign wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd)      count_d = count_q + 1'b1;
    else if (do_rd && !do_wr) count_d = count_q - 1'b1;
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with an edge-triggered enqueue port and a small byte FIFO;
// frames run back to back with one idle cycle between them.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_busy,
  output logic              tx_clear_req,
  output logic              tx_overflow,
  output logic              ser_tx
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_e         state_q, state_d;
  logic [15:0]       baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_start_q;
  logic              clear_q, clear_d;
  logic              overflow_q, overflow_d;

  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [PTR_W:0]    fifo_count;

  assign push = tx_start & ~tx_start_q;
  assign pop  = (state_q == IDLE) & ~fifo_empty;

  // A full FIFO still takes the byte when the same edge pops the head.
  assign overflow_d = overflow_q | (push & fifo_full & ~pop);

  assign tx_busy      = (state_q != IDLE) | (fifo_count != '0);
  assign tx_clear_req = clear_q;
  assign tx_overflow  = overflow_q;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (push),
    .wr_data_i (tx_data),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    clear_d = 1'b0;
    ser_tx  = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = fifo_head;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        ser_tx = 1'b0;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        ser_tx = shift_q[0];
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          clear_d = 1'b1;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_start_q <= 1'b0;
      clear_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_start_q <= tx_start;
      clear_q    <= clear_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level reference model checked every
// cycle, plus literal expectations for latency, frame shape, overflow and reset.
module tb_uart_tx;

  localparam int CPB      = 4;
  localparam int DEPTH    = 4;
  localparam int SLOW_CPB = 347;
  localparam int FRAME    = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy, tx_clear_req, tx_overflow, ser_tx;

  logic       s_start = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_busy, s_clear, s_ovf, s_ser;

  int n_checks = 0;
  int n_fail   = 0;
  int n_clr    = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clk), .reset(rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_clear_req(tx_clear_req), .tx_overflow(tx_overflow), .ser_tx(ser_tx)
  );

  uart_tx dut_slow (
    .clock(clk), .reset(rst), .tx_start(s_start), .tx_data(s_data),
    .tx_busy(s_busy), .tx_clear_req(s_clear), .tx_overflow(s_ovf), .ser_tx(s_ser)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the frame in flight, indexed by the
  // cycle count since its start bit began.
  logic [7:0] m_q[$];
  logic       m_active = 1'b0;
  logic [9:0] m_frame  = 10'h3FF;
  int         m_t      = 0;
  logic       m_clr    = 1'b0;
  logic       m_ovf    = 1'b0;
  logic       m_prev   = 1'b0;
  bit         m_push, m_pop;
  int         m_size0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_clr    = 1'b0;
      m_ovf    = 1'b0;
      m_prev   = 1'b0;
    end else begin
      m_push  = tx_start && !m_prev;
      m_prev  = tx_start;
      m_size0 = m_q.size();
      m_clr   = 1'b0;
      m_pop   = 1'b0;
      if (m_active) begin
        m_t++;
        if (m_t == FRAME) begin
          m_active = 1'b0;
          m_clr    = 1'b1;
        end
      end else if (m_size0 != 0) begin
        m_pop = 1'b1;
      end
      if (m_pop) begin
        m_frame  = {1'b1, m_q.pop_front(), 1'b0};
        m_active = 1'b1;
        m_t      = 0;
      end
      if (m_push) begin
        if (m_size0 < DEPTH || m_pop) m_q.push_back(tx_data);
        else                          m_ovf = 1'b1;
      end
    end
  end

  logic exp_ser;
  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      exp_ser = m_active ? m_frame[m_t / CPB] : 1'b1;
      check("ser_tx", ser_tx, exp_ser);
      check("tx_busy", tx_busy, m_active || (m_q.size() != 0));
      check("tx_clear_req", tx_clear_req, m_clr);
      check("tx_overflow", tx_overflow, m_ovf);
    end
    if (!rst && tx_clear_req) n_clr++;
  end

  // Called right after a negedge: one cycle high, one cycle low.
  task automatic pulse_start(input logic [7:0] d);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    for (n = 0; n < max_cycles; n++) begin
      @(negedge clk);
      if (!tx_busy) break;
    end
    check("drain_in_time", 32'(n < max_cycles), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, peak, clrs, lows, base, n;
    logic [39:0] cap;
    logic [9:0]  ef;
    logic [7:0]  rx;

    repeat (3) @(negedge clk);
    check("rst_ser_tx", ser_tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_clear", tx_clear_req, 0);
    check("rst_overflow", tx_overflow, 0);
    rst    = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5: latency, bit pattern, clear pulse, busy fall.
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) tx_start = 1'b0;
      lat++;
      if (!ser_tx) break;
    end
    check("start_latency", lat, 2);
    cap[0] = ser_tx;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      cap[k] = ser_tx;
    end
    check("busy_in_stop", tx_busy, 1);
    ef = 10'b1101001010;
    for (int b = 0; b < 10; b++) begin
      logic [3:0] slot;
      logic       eb;
      slot = cap[4*b +: 4];
      eb   = ef[b];
      check("a5_frame_bit", slot, eb ? 4'hF : 4'h0);
    end
    @(negedge clk);
    check("a5_clear_pulse", tx_clear_req, 1);
    check("a5_busy_fall", tx_busy, 0);
    @(negedge clk);
    check("a5_clear_once", tx_clear_req, 0);

    // tx_start held high: exactly one enqueue.
    tx_start = 1'b1;
    tx_data  = 8'h3C;
    peak = 0;
    clrs = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (c == 99) tx_start = 1'b0;
      if (int'(dut.u_fifo.count_o) > peak) peak = int'(dut.u_fifo.count_o);
      if (tx_clear_req) clrs++;
    end
    check("held_peak_count", peak, 1);
    check("held_frames", clrs, 1);

    // Five pushes while a frame is active: four queue, the fifth overflows.
    do_reset();
    @(negedge clk);
    base = n_clr;
    pulse_start(8'hC3);
    for (int b = 1; b <= 5; b++) pulse_start(8'(b));
    check("burst_overflow", tx_overflow, 1);
    wait_idle(5 * (FRAME + 1) + 20);
    check("burst_frames", n_clr - base, 5);

    // Push while full on the exact cycle IDLE pops: accepted, no overflow.
    do_reset();
    @(negedge clk);
    base = n_clr;
    pulse_start(8'h10);
    for (int b = 2; b <= 5; b++) pulse_start(8'(b * 16));
    check("full_count", dut.u_fifo.count_o, 4);
    for (n = 0; n < 60; n++) begin
      if (tx_clear_req) break;
      @(negedge clk);
    end
    check("pop_cycle_found", 32'(n < 60), 1);
    tx_start = 1'b1;
    tx_data  = 8'h60;
    @(negedge clk);
    tx_start = 1'b0;
    check("pop_push_overflow", tx_overflow, 0);
    check("pop_push_count", dut.u_fifo.count_o, 4);
    wait_idle(6 * (FRAME + 1) + 20);
    check("pop_push_frames", n_clr - base, 6);
    check("pop_push_no_ovf", tx_overflow, 0);

    // Reset mid-frame (DATA bit 3 of 0xFF) with two bytes queued.
    do_reset();
    @(negedge clk);
    pulse_start(8'hFF);
    pulse_start(8'h11);
    pulse_start(8'h22);
    repeat (12) @(negedge clk);
    check("pre_reset_busy", tx_busy, 1);
    check("pre_reset_state_data", 32'(dut.state_q), 32'(uart_pkg::DATA));
    #2 rst = 1'b1;
    #1;
    check("async_rst_ser", ser_tx, 1);
    check("async_rst_busy", tx_busy, 0);
    check("async_rst_state", 32'(dut.state_q), 32'(uart_pkg::IDLE));
    @(negedge clk);
    rst  = 1'b0;
    base = n_clr;
    lows = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (!ser_tx || tx_busy) lows++;
    end
    check("no_resume_activity", lows, 0);
    check("no_resume_frames", n_clr - base, 0);

    // tx_start already high at reset release enqueues on the first edge.
    @(negedge clk);
    rst      = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'h9A;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    base = n_clr;
    repeat (5) @(negedge clk);
    tx_start = 1'b0;
    wait_idle(FRAME + 20);
    check("release_high_frames", n_clr - base, 1);

    // Random stimulus against the model.
    for (int c = 0; c < 400; c++) begin
      tx_start = ($urandom_range(0, 9) < 3);
      tx_data  = 8'($urandom);
      @(negedge clk);
    end
    tx_start = 1'b0;
    wait_idle((DEPTH + 1) * (FRAME + 1) + 20);

    // Default-rate instance: decode one byte mid-bit.
    s_start = 1'b1;
    s_data  = 8'h55;
    @(negedge clk);
    s_start = 1'b0;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!s_ser) break;
    end
    check("slow_start_seen", 32'(n < 10), 1);
    repeat (SLOW_CPB / 2) @(negedge clk);
    check("slow_start_bit", s_ser, 0);
    for (int b = 0; b < 8; b++) begin
      repeat (SLOW_CPB) @(negedge clk);
      rx[b] = s_ser;
    end
    repeat (SLOW_CPB) @(negedge clk);
    check("slow_stop_bit", s_ser, 1);
    check("slow_rx_byte", rx, 8'h55);
    repeat (SLOW_CPB) @(negedge clk);
    check("slow_idle", s_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 347, SHALL be the clock cycles per serial bit (115200 baud at the 40 MHz bench clock); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL be the transmit FIFO entry count; power of two, at least 2.
REQ-003 clock  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 tx_start  input  1  SHALL be the byte enqueue request; the byte is sampled on the tx_start rising edge.
REQ-006 tx_data  input  8  SHALL be the byte to send, sampled with the tx_start rising edge.
REQ-007 tx_busy  output  1  SHALL be high while the FIFO is non-empty or a frame is being shifted.
REQ-008 tx_clear_req  output  1  SHALL be a one-cycle pulse when a frame's stop bit completes.
REQ-009 tx_overflow  output  1  SHALL be a sticky flag: a tx_start edge arrived while the FIFO was full.
REQ-010 ser_tx  output  1  SHALL be the serial line, idle high, 8N1, LSB first.

Function
REQ-011 Edge detection SHALL register tx_start (tx_start_q); a push request SHALL be tx_start & ~tx_start_q, so a level held high enqueues exactly once.
REQ-012 A push request with FIFO not full SHALL write tx_data at that edge; with FIFO full the byte SHALL be dropped and tx_overflow set.
REQ-013 A push request while full in the same cycle as a pop SHALL be accepted (the pop frees the slot first); the count is unchanged.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, STOP.
REQ-015 IDLE SHALL hold ser_tx=1; when the FIFO is non-empty, IDLE SHALL pop the head into the shift register, clear the baud and bit counters, and go to START.
REQ-016 START SHALL drive ser_tx=0 for CLKS_PER_BIT cycles and then go to DATA.
REQ-017 DATA SHALL drive shift[0] for CLKS_PER_BIT cycles per bit, shift right after each bit, and go to STOP after bit index 7.
REQ-018 STOP SHALL drive ser_tx=1 for CLKS_PER_BIT cycles.
REQ-019 On the STOP exit cycle, STOP SHALL pulse tx_clear_req and go to IDLE.
REQ-020 Frames SHALL run back to back: the next start bit begins one cycle after STOP exits (one IDLE cycle) when the FIFO is non-empty.
REQ-021 Latency SHALL be fixed: ser_tx falls 2 rising edges after the edge where tx_start=1 and tx_start_q=0 (one edge to write, one edge to pop), given an empty FIFO and IDLE.
REQ-022 The baud counter SHALL be 16 bits and count 0..CLKS_PER_BIT-1, wrapping to 0 at each bit boundary.
REQ-023 The bit counter SHALL be 3 bits.
REQ-024 FIFO pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-025 The count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-026 tx_busy SHALL be combinational from the state and the FIFO count.
REQ-027 tx_clear_req SHALL be registered.
REQ-028 tx_overflow SHALL clear only on reset.
REQ-029 tx_data SHALL be ignored except on accepted push edges.

Reset
REQ-030 Reset asserted SHALL immediately force ser_tx=1, tx_busy=0, tx_clear_req=0, tx_overflow=0, state=IDLE, FIFO empty, tx_start_q=0, and counters 0.
REQ-031 A reset mid-frame SHALL abort the frame and discard queued bytes; after release no partial frame is resumed.
REQ-032 If tx_start is already high at reset release, it SHALL enqueue a byte on the first post-reset edge, since tx_start_q resets to 0.

Structure
REQ-033 Package uart_pkg SHALL hold the state enum (IDLE, START, DATA, STOP), the CLKS_PER_BIT and FIFO_DEPTH defaults, and the 8-bit data width constant.
REQ-034 The FIFO SHALL be the single sub-module uart_tx_fifo: synchronous write/read, full/empty/count outputs, same clock and reset.
REQ-035 The FSM, baud counter and shifter SHALL stay in uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted)
REQ-036 Single byte 0xA5 -> ser_tx=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles; tx_clear_req pulses once; tx_busy falls the cycle after.
REQ-037 tx_start held high 100 cycles with tx_data=0x3C -> exactly one frame sent and FIFO count peaks at 1.
REQ-038 Five edges 0x01..0x05 in consecutive even cycles while the first frame is active -> bytes 0x01..0x04 sent in order with a 1-cycle IDLE gap; 0x05 dropped; tx_overflow=1.
REQ-039 Push while full on the exact cycle IDLE pops -> byte accepted, no overflow, all bytes sent in order.
REQ-040 Reset asserted during DATA bit 3 of 0xFF with 2 bytes queued -> ser_tx=1 within the same cycle, tx_busy=0, and no frame follows release.
REQ-041 Default CLKS_PER_BIT=347 in the full chip, byte 0x55 -> the bench tbuart receiver decodes 0x55.
